// File: rtl/add_serial_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : add_serial_param                                             |
// | Description : Digit-serial adder/subtractor. Two WIDTH-bit operands are    |
// |               consumed LSB-first, DIGIT bits per clock, behind a           |
// |               start/busy/done handshake. Produces the full-width result,   |
// |               unsigned carry-out and signed overflow.                      |
// | Options     : ADD_SERIAL_PARAM_SUB_EN - when defined the sub input selects |
// |               A - B; otherwise sub is ignored and only A + B is built.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module add_serial_param #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int C_N  = WIDTH / DIGIT;
  localparam int C_CW = (C_N > 1) ? $clog2(C_N) : 1;
  localparam logic [C_CW-1:0] C_LAST = C_CW'(C_N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [C_CW-1:0]  r_count;

  logic [WIDTH-1:0] w_b_load;
  logic             w_cin;
  logic [DIGIT:0]   w_dsum;
  logic             w_msb_cin;
  logic [WIDTH-1:0] w_digit_top;
  logic             w_accept;
  logic             w_last;

`ifdef ADD_SERIAL_PARAM_SUB_EN
  // Subtraction is A + ~B + 1: invert B at capture and seed the carry with 1.
  assign w_b_load = sub ? ~b : b;
  assign w_cin    = sub;
`else
  logic w_unused_sub;
  assign w_unused_sub = sub;
  assign w_b_load     = b;
  assign w_cin        = 1'b0;
`endif

  // One digit of the addition; the extra top bit is the digit carry-out.
  assign w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};

  // Carry into the digit's top bit, recovered from that bit's sum; on the
  // final digit this is the carry into the result MSB.
  assign w_msb_cin = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_dsum[DIGIT-1];

  // New digit positioned at the top of the result register.
  assign w_digit_top = WIDTH'(w_dsum[DIGIT-1:0]) << (WIDTH - DIGIT);

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_ADD) && (r_count == C_LAST);

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs; unused encoding falls back to IDLE.
  always_comb begin
    w_state_nxt = S_IDLE;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = start ? S_ADD : S_IDLE;
      end
      S_ADD: begin
        busy        = 1'b1;
        w_state_nxt = (r_count == C_LAST) ? S_DONE : S_ADD;
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture on acceptance, then one digit per ADD cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_load;
      r_carry <= w_cin;
      r_sum   <= '0;
      r_count <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == S_ADD) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_sum   <= (r_sum >> DIGIT) | w_digit_top;
      r_carry <= w_dsum[DIGIT];
      r_count <= r_count + C_CW'(1);
      if (w_last) begin
        r_cout <= w_dsum[DIGIT];
        r_ovf  <= w_msb_cin ^ w_dsum[DIGIT];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_add_serial_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_add_serial_param                                          |
// | Description : Self-checking bench for add_serial_param. Main instance is   |
// |               16-bit/1-bit-digit with a scoreboard monitor; two extra      |
// |               instances cover 16/4 and 32/8 digit configurations.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_add_serial_param;

  localparam int N0 = 16;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // Main instance (WIDTH=16, DIGIT=1)
  logic        start, sub;
  logic [15:0] a, b, sum0;
  logic        busy0, done0, cout0, ovf0;

  // 16/4 instance
  logic        start4;
  logic [15:0] a4, b4, sum4;
  logic        busy4, done4, cout4, ovf4;

  // 32/8 instance
  logic        start8;
  logic [31:0] a8, b8, sum8;
  logic        busy8, done8, cout8, ovf8;
  logic        subx;

  vec_t        vecs[8];
  vec_t        exp_q[$];
  vec_t        e_mon;
  logic        prev_busy = 1'b0;
  logic        cont = 1'b0;
  logic        have_acc = 1'b0;
  int          last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  add_serial_param #(.WIDTH(16), .DIGIT(1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sub(sub),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0)
  );

  add_serial_param #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .sub(subx),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  add_serial_param #(.WIDTH(32), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .sub(subx),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor for the main instance: acceptance timing and results.
  always @(negedge clk) begin
    if (busy0 && !prev_busy) begin
      if (cont) begin
        if (have_acc) chk("start_spacing", cyc - last_acc, N0 + 2);
        have_acc = 1'b1;
      end else begin
        have_acc = 1'b0;
      end
      last_acc = cyc;
    end
    prev_busy = busy0;
    if (done0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        e_mon = exp_q.pop_front();
        chk("sum", {16'h0, sum0}, {16'h0, e_mon.s});
        chk("cout", {31'h0, cout0}, {31'h0, e_mon.c});
        chk("ovf", {31'h0, ovf0}, {31'h0, e_mon.o});
        chk("latency", cyc - last_acc, N0);
      end
    end
  end

  task automatic run_op(input vec_t v);
    int k;
    @(negedge clk);
    a = v.a; b = v.b; sub = v.sub; start = 1'b1;
    exp_q.push_back(v);
    @(negedge clk);
    start = 1'b0;
    chk("accept", {31'h0, busy0}, 32'h1);
    a = ~v.a; b = 16'($urandom); sub = ~v.sub;
    k = 0;
    while (!done0 && k < N0 + 4) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", {31'h0, done0}, 32'h1);
    @(negedge clk);
  endtask

  task automatic run_aux(input int sel, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] es, input logic ec, input logic eo, input int n);
    int k;
    int t0;
    logic [31:0] rs;
    @(negedge clk);
    if (sel == 4) begin a4 = av[15:0]; b4 = bv[15:0]; start4 = 1'b1; end
    else begin a8 = av; b8 = bv; start8 = 1'b1; end
    @(negedge clk);
    start4 = 1'b0; start8 = 1'b0;
    t0 = cyc;
    chk("aux_accept", {31'h0, (sel == 4) ? busy4 : busy8}, 32'h1);
    a4 = 16'($urandom); b4 = 16'($urandom); a8 = $urandom; b8 = $urandom;
    k = 0;
    while (!((sel == 4) ? done4 : done8) && k < n + 4) begin
      @(negedge clk);
      k++;
    end
    chk("aux_latency", cyc - t0, n);
    rs = (sel == 4) ? {16'h0, sum4} : sum8;
    chk("aux_sum", rs, es);
    chk("aux_cout", {31'h0, (sel == 4) ? cout4 : cout8}, {31'h0, ec});
    chk("aux_ovf", {31'h0, (sel == 4) ? ovf4 : ovf8}, {31'h0, eo});
    @(negedge clk);
  endtask

  initial begin
    int   k;
    logic seen;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0; subx = 1'b0;

    //            a         b        sub   sum       cout  ovf
    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
`ifdef ADD_SERIAL_PARAM_SUB_EN
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
`else
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'h000C, 1'b0, 1'b0};
    vecs[4] = '{16'h0007, 16'h0005, 1'b1, 16'h000C, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h0001, 1'b1, 16'h8001, 1'b0, 1'b0};
`endif

    // Reset state
    @(negedge clk);
    chk("rst_busy", {31'h0, busy0}, 32'h0);
    chk("rst_done", {31'h0, done0}, 32'h0);
    chk("rst_sum", {16'h0, sum0}, 32'h0);
    chk("rst_cout", {31'h0, cout0}, 32'h0);
    chk("rst_ovf", {31'h0, ovf0}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven operations
    for (int i = 0; i < 8; i++) run_op(vecs[i]);

    // Result holds in IDLE while start stays low
    repeat (5) @(negedge clk);
    chk("hold_sum", {16'h0, sum0}, {16'h0, vecs[7].s});
    chk("hold_busy", {31'h0, busy0}, 32'h0);

    // start held high: accepted every N+2 cycles, junk during busy ignored
    cont  = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      while (busy0 && k < N0 + 4) begin
        @(negedge clk);
        k++;
      end
      chk("cont_idle", {31'h0, busy0}, 32'h0);
      a = (i % 2 == 0) ? vecs[0].a : vecs[2].a;
      b = (i % 2 == 0) ? vecs[0].b : vecs[2].b;
      sub = 1'b0;
      exp_q.push_back((i % 2 == 0) ? vecs[0] : vecs[2]);
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom);
    end
    start = 1'b0;
    k = 0;
    while (!done0 && k < N0 + 4) begin
      @(negedge clk);
      k++;
    end
    chk("cont_done", {31'h0, done0}, 32'h1);
    @(negedge clk);
    cont = 1'b0;
    chk("cont_drained", exp_q.size(), 0);

    // Asynchronous reset during ADD cycle 5
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0000; sub = 1'b0; start = 1'b1;
    exp_q.push_back(vecs[1]);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("arst_busy", {31'h0, busy0}, 32'h0);
    chk("arst_done", {31'h0, done0}, 32'h0);
    chk("arst_sum", {16'h0, sum0}, 32'h0);
    chk("arst_cout", {31'h0, cout0}, 32'h0);
    chk("arst_ovf", {31'h0, ovf0}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (N0 + 3) begin
      @(negedge clk);
      if (done0) seen = 1'b1;
    end
    chk("no_done_after_rst", {31'h0, seen}, 32'h0);
    run_op(vecs[1]);

    // Wider digit configurations
    run_aux(4, 32'h1234, 32'h0FCD, 32'h2201, 1'b0, 1'b0, 4);
    run_aux(8, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 4);
    run_aux(8, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 4);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
